// File: rtl/major_state_seq_pkg.sv
// rtl/major_state_seq_pkg.sv - major-state codes, opcode constants and HLT decode for the PDP-8/e sequencer
package major_state_seq_pkg;

    typedef enum logic [4:0] {
        F0 = 5'h00, F1 = 5'h01, F2 = 5'h02, F3 = 5'h03,
        D0 = 5'h04, D1 = 5'h05, D2 = 5'h06, D3 = 5'h07,
        E0 = 5'h08, E1 = 5'h09, E2 = 5'h0A, E3 = 5'h0B,
        H0 = 5'h1F
    } state_t;

    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    // Group 2 OPR with the HLT bit set (e.g. 7402).
    function automatic logic is_hlt(input logic [0:11] ins);
        return (ins[0:3] == 4'b1111) && ins[10] && !ins[11];
    endfunction

endpackage

// File: rtl/major_state_seq.sv
// rtl/major_state_seq.sv - Fetch/Defer/Execute major-state sequencer with run/stop/single-step control
module major_state_seq
    import major_state_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] instruction,
    input  logic        cont,
    input  logic        sstep,
    input  logic        stop,
    output logic [4:0]  state,
    output logic        run
);

    state_t state_q, state_d;
    logic   run_q, run_d;
    logic   stop_pend_q, stop_pend_d;
    logic   step_pend_q, step_pend_d;
    logic   end_of_instr;

    logic [2:0] opcode;
    logic       ind;
    logic       unused_bits;

    assign opcode      = instruction[0:2];
    assign ind         = instruction[3];
    assign unused_bits = ^instruction[4:9];

    always_comb begin
        state_d      = state_q;
        stop_pend_d  = stop_pend_q;
        step_pend_d  = step_pend_q;
        end_of_instr = 1'b0;

        if (stop && state_q != H0)
            stop_pend_d = 1'b1;

        case (state_q)
            H0: if (cont && !stop) begin
                    state_d     = F0;
                    step_pend_d = sstep;
                end
            F0: state_d = F1;
            F1: state_d = F2;
            F2: state_d = F3;
            F3: begin
                if (opcode == OP_IOT || opcode == OP_OPR || (opcode == OP_JMP && !ind))
                    end_of_instr = 1'b1;
                else if (ind)
                    state_d = D0;
                else
                    state_d = E0;
            end
            D0: state_d = D1;
            D1: state_d = D2;
            D2: state_d = D3;
            D3: begin
                if (opcode == OP_JMP)
                    end_of_instr = 1'b1;
                else
                    state_d = E0;
            end
            E0: state_d = E1;
            E1: state_d = E2;
            E2: state_d = E3;
            E3: end_of_instr = 1'b1;
            default: state_d = H0;
        endcase

        // A stop arriving on the x3 cycle itself is already folded into stop_pend_d.
        if (end_of_instr)
            state_d = (is_hlt(instruction) || stop_pend_d || step_pend_q) ? H0 : F0;

        if (state_d == H0) begin
            stop_pend_d = 1'b0;
            step_pend_d = 1'b0;
        end

        run_d = (state_d != H0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= H0;
            run_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            stop_pend_q <= stop_pend_d;
            step_pend_q <= step_pend_d;
        end
    end

    assign state = state_q;
    assign run   = run_q;

endmodule

// File: tb/tb_major_state_seq.sv
// tb/tb_major_state_seq.sv - self-checking bench for major_state_seq against an instruction-level model
module tb_major_state_seq;
    import major_state_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:11] instruction;
    logic        cont;
    logic        sstep;
    logic        stop;
    logic [4:0]  state;
    logic        run;

    int n_pass  = 0;
    int n_total = 0;
    bit step_mode = 1'b0;

    major_state_seq dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .cont        (cont),
        .sstep       (sstep),
        .stop        (stop),
        .state       (state),
        .run         (run)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse cont in H0; a simultaneous stop must keep the sequencer halted.
    task automatic start(input bit ss, input bit with_stop);
        cont  = 1'b1;
        sstep = ss;
        stop  = with_stop;
        step();
        cont  = 1'b0;
        stop  = 1'b0;
        chk("start_state", state, with_stop ? H0 : F0);
        chk("start_run", {4'b0, run}, {4'b0, !with_stop});
        step_mode = ss && !with_stop;
    endtask

    // From F0, run one instruction; stop_at indexes the cycle of the sequence in which stop pulses.
    task automatic exec(input logic [11:0] w, input int stop_at, output bit halted);
        state_t seq[$];
        int     op;
        bit     ind, hlt;
        op  = int'(w[11:9]);
        ind = w[8];
        hlt = (w[11:8] == 4'hF) && w[1] && !w[0];
        seq = '{F0, F1, F2, F3};
        if (ind && op <= 5) begin
            seq.push_back(D0); seq.push_back(D1); seq.push_back(D2); seq.push_back(D3);
        end
        if (op <= 4) begin
            seq.push_back(E0); seq.push_back(E1); seq.push_back(E2); seq.push_back(E3);
        end
        instruction = w;
        chk("at_f0", state, F0);
        for (int i = 1; i <= seq.size(); i++) begin
            stop  = (i - 1 == stop_at);
            cont  = 1'($urandom_range(0, 1));
            sstep = 1'($urandom_range(0, 1));
            step();
            stop = 1'b0;
            cont = 1'b0;
            if (i < seq.size()) begin
                chk("seq_state", state, seq[i]);
                chk("seq_run", {4'b0, run}, 5'd1);
            end
        end
        halted = hlt || (stop_at >= 0 && stop_at < seq.size()) || step_mode;
        chk("eoi_state", state, halted ? H0 : F0);
        chk("eoi_run", {4'b0, run}, {4'b0, !halted});
        if (halted) step_mode = 1'b0;
    endtask

    initial begin
        bit h;
        reset = 1'b1; cont = 1'b0; sstep = 1'b0; stop = 1'b0; instruction = 12'o0;
        step();
        step();
        chk("reset_state", state, H0);
        chk("reset_run", {4'b0, run}, 5'd0);
        reset = 1'b0;
        step();
        chk("idle_state", state, H0);

        // JMS direct then HLT
        start(1'b0, 1'b0);
        exec(12'o4123, -1, h);
        exec(12'o7402, -1, h);

        // JMP I, TAD I
        start(1'b0, 1'b0);
        exec(12'o5600, -1, h);
        exec(12'o1600, -1, h);
        exec(12'o7402, -1, h);

        // single step: one NOP per cont
        start(1'b1, 1'b0);
        exec(12'o7000, -1, h);
        start(1'b1, 1'b0);
        exec(12'o7000, -1, h);

        // stop in E1 of ISZ
        start(1'b0, 1'b0);
        exec(12'o2100, 5, h);

        // cont+stop together in H0
        start(1'b0, 1'b1);
        step();
        chk("hold_h0", state, H0);

        // stop while halted must not leave a pending stop
        stop = 1'b1;
        step();
        stop = 1'b0;
        start(1'b0, 1'b0);
        exec(12'o7000, -1, h);
        exec(12'o7402, -1, h);

        // reset during D1
        start(1'b0, 1'b0);
        instruction = 12'o1600;
        step(); chk("d_f1", state, F1);
        step(); chk("d_f2", state, F2);
        step(); chk("d_f3", state, F3);
        step(); chk("d_d0", state, D0);
        step(); chk("d_d1", state, D1);
        reset = 1'b1;
        step();
        chk("mid_reset_state", state, H0);
        chk("mid_reset_run", {4'b0, run}, 5'd0);
        reset = 1'b0;
        start(1'b0, 1'b0);
        exec(12'o7402, -1, h);

        // randomized instruction streams
        for (int r = 0; r < 40; r++) begin
            bit ss;
            ss = ($urandom_range(0, 3) == 0);
            start(ss, 1'b0);
            for (int k = 0; k < 10; k++) begin
                logic [11:0] w;
                int          sa;
                w  = 12'($urandom_range(0, 4095));
                if ($urandom_range(0, 5) == 0 || k == 9) w = 12'o7402;
                sa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 11)) : -1;
                exec(w, sa, h);
                if (h) break;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/major_state_seq.md
# major_state_seq

Major-state sequencer for the PDP-8/e core. Generates the 5-bit `state` bus that `ma`, `pc` and the AC/ALU logic consume. It steps the Fetch (F0–F3), Defer (D0–D3) and Execute (E0–E3) major cycles. The next major cycle is chosen from the opcode and indirect bit of the current instruction. It also handles run, stop and single-step control from the front panel, and halt on HLT.

## Interface
Parameters:
- None. State codes come from the shared `parameters.v`.

Ports:
- `clk`  in  1  system clock. One clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instruction`  in  [0:11]  current instruction from `ma`. Valid from F1 through the end of the instruction.
- `cont`  in  1  front-panel Continue, one-cycle pulse, already synchronised.
- `sstep`  in  1  single-step mode level. While 1, exactly one instruction runs per `cont`.
- `stop`  in  1  front-panel Stop, one-cycle pulse.
- `state`  out  [4:0]  current major state code.
- `run`  out  1  run indicator. 1 whenever `state` is not H0.

## Operation
- States: H0 (halted/idle), F0–F3, D0–D3, E0–E3.
- Within a major cycle the sequence is always x0→x1→x2→x3, one state per clock, with no stalls.
- Decode at F3, using opcode = `instruction[0:2]` and indirect bit I = `instruction[3]`:
  - opcode 6 (IOT) or 7 (OPR), or opcode 5 (JMP) with I=0 → end of instruction.
  - opcode 0–5 with I=1 → D0.
  - opcode 0–4 with I=0 → E0.
- At D3: opcode 5 → end of instruction; otherwise → E0.
- At E3: always end of instruction.
- HLT is `instruction[0:3]`=4'b1111 with `instruction[11]`=0 and `instruction[10]`=1 (group 2 OPR, e.g. 12'o7402). HLT forces end of instruction to go to H0.
- End of instruction resolves in this priority order:
  - HLT, stop_pending or step_pending → H0.
  - Otherwise → F0.
- `stop_pending` is set by `stop` in any non-H0 state. It is cleared on entry to H0.
- `step_pending` is set when leaving H0 via `cont` while `sstep`=1. It is cleared on entry to H0.
- In H0:
  - `cont`=1 and `stop`=0 → F0 next clock.
  - Otherwise stay in H0. Stop wins over a simultaneous cont.
- Panel load/deposit/examine are not sequenced here; `ma` handles them while `state`=H0.
- Interrupts are out of scope for this block. Any future interrupt entry is inserted at end of instruction.

## Timing
- Reset: `state`=H0, `run`=0, and `stop_pending` and `step_pending` both cleared. Reset takes effect on the next edge from any state, including mid-cycle (e.g. D1).
- `state` is registered. `run` is registered and changes on the same edge as `state`.
- The decode inputs (`instruction`, the flags) are sampled at the clock edge that leaves F3, D3 or E3. `instruction` must be stable from F1 onward.
- Instruction lengths:
  - Fetch-only: 4 clocks.
  - Direct memory reference: 8 clocks.
  - JMP I: 8 clocks.
  - Indirect non-JMP: 12 clocks.
- Latency from `cont` in H0 to F0 is 1 clock.
- Latency from `stop` to H0 is the remainder of the current instruction plus 1 clock. A `stop` arriving in the same cycle as x3 still takes effect at that boundary.
- `cont` pulses outside H0 are ignored.

## Structure
- `parameters.v` (shared package) holds the F0–F3, D0–D3, E0–E3 codes already used by `ma` and `pc`, plus the new H0 code. All codes are 5-bit and unique.
- The block is one module. It has one natural combinational sub-function, `end_of_instr` decode, which is kept inline as an always block rather than a separate module.
- Opcode constants (JMP=5, IOT=6, OPR=7) are added to `parameters.v`.

## Test plan
- Reset, then `cont`, with memory holding 12'o4xxx (JMS, direct) and then 12'o7402 → F0..F3, E0..E3, F0..F3, H0. `run` falls on the H0 edge.
- 12'o5600 (JMP I) → F0..F3, D0..D3, F0, with no E states.
- 12'o1600 (TAD I) → F0..F3, D0..D3, E0..E3, F0.
- `sstep`=1 with `cont` on a stream of 12'o7000 (NOP) → exactly F0..F3 then H0. A second `cont` runs exactly one more instruction.
- Stop in E1 of a 12'o2xxx (ISZ) → completes E3, then H0. Simultaneous `cont`+`stop` in H0 → stays in H0.
- `reset` asserted during D1 → `state`=H0 and `run`=0 on the next edge. A subsequent `cont` starts cleanly at F0.
